// File: rtl/led_seq_pkg.sv
// LED sequencer shared types: engine modes, FSM states
// and register offsets relative to the LED data address.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC,
    MODE_BLINK,
    MODE_ROL,
    MODE_ROR
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_UPDATE
  } state_e;

  localparam logic [11:0] OFS_CTRL    = 12'd4;
  localparam logic [11:0] OFS_PERIOD  = 12'd8;
  localparam logic [11:0] OFS_PATTERN = 12'd12;
  localparam logic [11:0] OFS_STEP    = 12'd16;

endpackage

// File: rtl/led_seq_prescaler.sv
// Tick prescaler: counts while en, ticks when cnt==period.
// Ports: clk_i, rst_i, clr, en, period -> tick.
module led_seq_prescaler #(
  parameter int CNT_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == period);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: CTRL/PERIOD/PATTERN regs, pattern engine,
// and CPU-vs-engine arbitration onto the LED write port.
// Ports: clk_i, rst_i, bus_wen/addr/wdata, bus_rdata,
// led_wen/addr/wdata, busy.
// Option: LED_SEQ_STEPCNT_EN adds a step counter at BASE+16.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int          CNT_W = 24,
  parameter int          LED_W = 24,
  parameter logic [11:0] BASE  = 12'h060
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_wen,
  input  logic [11:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        led_wen,
  output logic [11:0] led_addr,
  output logic [31:0] led_wdata,
  output logic        busy
);

  state_e           state, state_n;
  mode_e            mode;
  logic             en;
  logic [CNT_W-1:0] period;
  logic [LED_W-1:0] pattern;
  logic [LED_W-1:0] cur;
  logic [LED_W-1:0] eng_val;
  logic             phase;
  logic             tick;
  logic             wr_base, wr_ctrl;
  logic             wr_period, wr_pattern;
  logic             dis, issue, step_ok;
  logic [31:0]      rd_n;
  logic             unused_wdata;

  assign unused_wdata = ^bus_wdata[31:LED_W];

  assign wr_base    = bus_wen && bus_addr == BASE;
  assign wr_ctrl    = bus_wen &&
                      bus_addr == BASE + OFS_CTRL;
  assign wr_period  = bus_wen &&
                      bus_addr == BASE + OFS_PERIOD;
  assign wr_pattern = bus_wen &&
                      bus_addr == BASE + OFS_PATTERN;

  // Disabling wins over a pending engine write;
  // a CPU LED write defers it by one cycle.
  assign dis   = wr_ctrl && !bus_wdata[0];
  assign issue = (state == ST_LOAD ||
                  state == ST_UPDATE) &&
                 !wr_base && !dis;

  assign step_ok = mode != MODE_STATIC && tick;

  led_seq_prescaler #(.CNT_W(CNT_W)) u_presc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (wr_period || state == ST_LOAD),
    .en    (state == ST_RUN ||
            state == ST_UPDATE),
    .period(period),
    .tick  (tick)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:
        if (wr_ctrl && bus_wdata[0])
          state_n = ST_LOAD;
      ST_LOAD:
        if (issue) state_n = ST_RUN;
      ST_RUN:
        if (step_ok) state_n = ST_UPDATE;
      ST_UPDATE:
        if (issue)
          state_n = step_ok ? ST_UPDATE : ST_RUN;
    endcase
    if (dis) state_n = ST_IDLE;
  end

  // Computed from cur at issue time, so a CPU write
  // that deferred this update is rotated as well.
  always_comb begin
    eng_val = cur;
    if (state == ST_LOAD) begin
      eng_val = pattern;
    end else begin
      unique case (mode)
        MODE_STATIC: eng_val = cur;
        MODE_BLINK:  eng_val = phase ? cur : '0;
        MODE_ROL:    eng_val = {cur[LED_W-2:0],
                                cur[LED_W-1]};
        MODE_ROR:    eng_val = {cur[0],
                                cur[LED_W-1:1]};
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      en        <= 1'b0;
      mode      <= MODE_STATIC;
      period    <= '0;
      pattern   <= '0;
      cur       <= '0;
      phase     <= 1'b0;
      led_wen   <= 1'b0;
      led_addr  <= '0;
      led_wdata <= '0;
    end else begin
      state    <= state_n;
      busy     <= state_n == ST_RUN ||
                  state_n == ST_UPDATE;
      led_wen  <= 1'b0;
      led_addr <= '0;
      if (issue) begin
        led_wen   <= 1'b1;
        led_addr  <= BASE;
        led_wdata <= {{(32-LED_W){1'b0}}, eng_val};
        if (state == ST_LOAD) begin
          cur   <= eng_val;
          phase <= 1'b0;
        end else if (mode == MODE_BLINK) begin
          phase <= ~phase;
        end else if (mode != MODE_STATIC) begin
          cur <= eng_val;
        end
      end
      if (wr_ctrl) begin
        en   <= bus_wdata[0];
        mode <= mode_e'(bus_wdata[2:1]);
      end
      if (wr_period)
        period <= bus_wdata[CNT_W-1:0];
      if (wr_pattern || wr_base) begin
        pattern <= bus_wdata[LED_W-1:0];
        cur     <= bus_wdata[LED_W-1:0];
      end
      if (wr_base) begin
        led_wen   <= 1'b1;
        led_addr  <= BASE;
        led_wdata <= {{(32-LED_W){1'b0}},
                      bus_wdata[LED_W-1:0]};
      end
    end
  end

`ifdef LED_SEQ_STEPCNT_EN
  logic [15:0] step;
  logic        wr_step;

  assign wr_step = bus_wen &&
                   bus_addr == BASE + OFS_STEP;

  always_ff @(posedge clk_i) begin
    if (rst_i || wr_step) step <= '0;
    else if (issue)       step <= step + 16'd1;
  end
`endif

  always_comb begin
    rd_n = '0;
    if (bus_addr == BASE + OFS_CTRL)
      rd_n = {29'b0, mode, en};
    else if (bus_addr == BASE + OFS_PERIOD)
      rd_n = {{(32-CNT_W){1'b0}}, period};
    else if (bus_addr == BASE + OFS_PATTERN)
      rd_n = {{(32-LED_W){1'b0}}, pattern};
`ifdef LED_SEQ_STEPCNT_EN
    else if (bus_addr == BASE + OFS_STEP)
      rd_n = {16'b0, step};
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) bus_rdata <= '0;
    else       bus_rdata <= rd_n;
  end

endmodule
